// File: rtl/layer4_pkg.sv
// layer4_pkg: constants and types shared by the layer4 parameter-load path
// (parameter geometry, parameter group names, streamer FSM state encoding).
package layer4_pkg;

    localparam int PARA_WIDTH   = 16;
    localparam int PARA_NUM     = 6;
    localparam int FM_DEPTH     = 128;
    localparam int LOG2FM_DEPTH = 7;

    typedef enum logic [2:0] {
        GRP_RSIGN = 3'd0,
        GRP_BN_A  = 3'd1,
        GRP_BN_B  = 3'd2,
        GRP_BETA  = 3'd3,
        GRP_GAMMA = 3'd4,
        GRP_ZETA  = 3'd5
    } grp_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DRAIN  = 3'd2;
    localparam state_t ST_FINISH = 3'd3;
    localparam state_t ST_RUN    = 3'd4;

endpackage

// File: rtl/para_streamer_layer4_if.sv
// para_streamer_layer4_if: parameter SRAM read port (grant, strobe, address, 1-cycle read data).
interface para_streamer_layer4_if #(
    parameter int ADDR_W     = 16,
    parameter int PARA_WIDTH = layer4_pkg::PARA_WIDTH
) ();

    logic                  mem_gnt;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [PARA_WIDTH-1:0] mem_rdata;

    modport master (input mem_gnt, input mem_rdata, output mem_rd_en, output mem_addr);
    modport slave  (output mem_gnt, output mem_rdata, input mem_rd_en, input mem_addr);

endinterface

// File: rtl/para_streamer_layer4.sv
// para_streamer_layer4: fetches PARA_NUM x FM_DEPTH words from parameter SRAM and streams them to
// the layer4 para_loader, then raises mode_out. Macro PARA_STREAMER_CHECKSUM_EN adds a checksum word.
module para_streamer_layer4 #(
    parameter int FM_DEPTH     = layer4_pkg::FM_DEPTH,
    parameter int LOG2FM_DEPTH = layer4_pkg::LOG2FM_DEPTH,
    parameter int PARA_NUM     = layer4_pkg::PARA_NUM,
    parameter int PARA_WIDTH   = layer4_pkg::PARA_WIDTH,
    parameter int ADDR_W       = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    para_streamer_layer4_if.master  mem,
    output logic                    mode_out,
    output logic                    data_e_out,
    output logic [PARA_WIDTH-1:0]   para_out,
    output logic [2:0]              grp_out,
    output logic [LOG2FM_DEPTH-1:0] idx_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    import layer4_pkg::*;

    localparam int TOTAL = PARA_NUM * FM_DEPTH;
`ifdef PARA_STREAMER_CHECKSUM_EN
    localparam int LAST_RD = TOTAL;
`else
    localparam int LAST_RD = TOTAL - 1;
`endif
    localparam int CNT_W = $clog2(TOTAL + 1);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_rd_cnt;
    logic [ADDR_W-1:0]       r_base;
    logic [2:0]              r_grp_cnt;
    logic [LOG2FM_DEPTH-1:0] r_idx_cnt;
    logic                    r_all_out;
    logic                    r_vld_p0;
    logic                    r_vld_p1;
    logic [PARA_WIDTH-1:0]   r_para_p1;
    logic [2:0]              r_grp_p1;
    logic [LOG2FM_DEPTH-1:0] r_idx_p1;

    logic w_start_ok;
    logic w_rd;
    logic w_last_rd;
    logic w_cap;
    logic w_last_word;

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_rd        = (r_state == ST_FETCH) && mem.mem_gnt;
    assign w_last_rd   = w_rd && (r_rd_cnt == CNT_W'(LAST_RD));
    // Once every data word is out, a further returning read can only be the checksum word.
    assign w_cap       = r_vld_p0 && !r_all_out;
    assign w_last_word = w_cap && (r_grp_cnt == 3'(PARA_NUM - 1))
                               && (r_idx_cnt == LOG2FM_DEPTH'(FM_DEPTH - 1));

    assign mem.mem_rd_en = w_rd;
    assign mem.mem_addr  = w_rd ? (r_base + ADDR_W'(r_rd_cnt)) : '0;

    assign mode_out   = (r_state == ST_RUN);
    assign busy       = (r_state == ST_FETCH) || (r_state == ST_DRAIN) || (r_state == ST_FINISH);
    assign done       = (r_state == ST_FINISH);
    assign data_e_out = r_vld_p1;
    assign para_out   = r_para_p1;
    assign grp_out    = r_grp_p1;
    assign idx_out    = r_idx_p1;

`ifdef PARA_STREAMER_CHECKSUM_EN
    logic [PARA_WIDTH-1:0] r_sum;
    logic                  r_err;
    logic                  w_ck_arrive;

    function automatic logic [PARA_WIDTH-1:0] csum_add(input logic [PARA_WIDTH-1:0] a,
                                                       input logic [PARA_WIDTH-1:0] b);
        return a + b;
    endfunction

    assign w_ck_arrive = r_vld_p0 && r_all_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_cap)       r_sum <= csum_add(r_sum, mem.mem_rdata);
            if (w_ck_arrive) r_err <= (mem.mem_rdata != r_sum);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: if (w_start_ok) r_state <= ST_FETCH;
                ST_FETCH:        if (w_last_rd)  r_state <= ST_DRAIN;
`ifdef PARA_STREAMER_CHECKSUM_EN
                ST_DRAIN:        if (w_ck_arrive) r_state <= ST_FINISH;
                ST_FINISH:       r_state <= r_err ? ST_IDLE : ST_RUN;
`else
                ST_DRAIN:        if (r_all_out) r_state <= ST_FINISH;
                ST_FINISH:       r_state <= ST_RUN;
`endif
                default:         r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_cnt  <= '0;
            r_base    <= '0;
            r_grp_cnt <= '0;
            r_idx_cnt <= '0;
            r_all_out <= 1'b0;
        end else if (w_start_ok) begin
            r_rd_cnt  <= '0;
            r_base    <= base_addr;
            r_grp_cnt <= '0;
            r_idx_cnt <= '0;
            r_all_out <= 1'b0;
        end else begin
            if (w_rd) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            if (w_cap) begin
                if (r_idx_cnt == LOG2FM_DEPTH'(FM_DEPTH - 1)) begin
                    r_idx_cnt <= '0;
                    r_grp_cnt <= r_grp_cnt + 3'd1;
                end else begin
                    r_idx_cnt <= r_idx_cnt + LOG2FM_DEPTH'(1);
                end
            end
            if (w_last_word) r_all_out <= 1'b1;
        end
    end

    // p0: SRAM read data valid; p1: registered word presented to the para_loader
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_para_p1 <= '0;
            r_grp_p1  <= '0;
            r_idx_p1  <= '0;
        end else begin
            r_vld_p0 <= w_rd;
            r_vld_p1 <= w_cap;
            if (w_cap) begin
                r_para_p1 <= mem.mem_rdata;
                r_grp_p1  <= r_grp_cnt;
                r_idx_p1  <= r_idx_cnt;
            end
        end
    end

endmodule
